mmio_console_monitor: RTL and testbench
=======================================

Name: mmio_console_monitor

Overview:
- Memory-mapped console and test-status monitor that snoops the core's data-memory store port (memwrite/dataadr/writedata).
- Stores to the console address are buffered in a parametrised FIFO and drained over a valid/ready character stream.
- Stores to the tohost address end the test with a pass or fail code; a cycle watchdog flags hung programs.
- Used by 5-stage and future cores, so program exit no longer relies on fixed-delay benches.

Parameters:
CONSOLE_ADDR, 32'd65532, word address whose stores push writedata[CHAR_W-1:0] into the FIFO
TOHOST_ADDR, 32'd65528, word address whose stores signal end-of-test
FIFO_DEPTH, 16, character buffer entries; power of two, >=2
CHAR_W, 8, character width in bits
TIMEOUT_CYCLES, 200, cycles after reset release before timeout; 0 disables the watchdog

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
memwrite  input  1  store strobe from the core's memory stage
dataadr  input  32  store address
writedata  input  32  store data
char_ready  input  1  sink accepts char_data this cycle
char_valid  output  1  char_data is valid
char_data  output  CHAR_W  head-of-FIFO character
fifo_overflow  output  1  sticky; a console store was dropped
done  output  1  test finished and FIFO drained
pass  output  1  valid when done; tohost value was 1
fail_code  output  31  valid when done; tohost value >> 1 on fail
timeout  output  1  sticky; the watchdog expired

Behaviour:
- Reset (async): FIFO empty; all outputs 0; cycle counter 0; state RUN.
- Console push: memwrite && dataadr==CONSOLE_ADDR, state RUN.
  - Pushes the character. char_valid rises on the next clk edge, a 1-cycle latency.
- Pop: char_valid && char_ready. The FIFO advances at the edge.
  - char_data is held stable while char_valid && !char_ready.
- Full FIFO:
  - A push is accepted only if a pop occurs in the same cycle.
  - Otherwise the push is dropped and fifo_overflow sets; it clears only on reset.
- Empty FIFO with a simultaneous push and pop: no pop occurs because char_valid=0; the push is accepted.
- Pointers: log2(FIFO_DEPTH) bits plus one wrap bit, wrapping modulo depth. Full/empty are decoded from the wrap bit.
- tohost store: memwrite && dataadr==TOHOST_ADDR && writedata[0]==1, state RUN.
  - Latches pass = (writedata==1) and fail_code = writedata[31:1], or 0 when pass.
  - Moves to state DRAIN.
  - A tohost store with bit0=0 is ignored.
- Watchdog: the counter increments each cycle in RUN. At count==TIMEOUT_CYCLES-1, timeout sets, pass=0, and the state moves to DRAIN.
  - A tohost store in the same cycle takes priority; timeout stays 0.
- States:
  - RUN: accepts console and tohost stores.
  - DRAIN: ignores all stores and pops until the FIFO is empty, then moves to DONE.
  - DONE: done=1, held; all stores ignored; pass/fail_code/timeout held until reset.
- Console and tohost stores in the same cycle cannot occur because the addresses differ. Other addresses are ignored.
- Reset mid-operation discards buffered characters and clears done/pass/timeout immediately.

Optional Feature:
CONSOLE_SIM_PRINT_EN
- Defined: each pop also issues $write("%c", char_data). Entry to DONE prints a PASS, FAIL <code> or TIMEOUT line, then calls $finish.
- Undefined: no system tasks; the block is fully synthesizable and has identical port behaviour.

Decomposition:
- Package console_pkg:
  - console_state_t enum {RUN, DRAIN, DONE}.
  - Default CONSOLE_ADDR/TOHOST_ADDR localparams.
  - Function fifo_ptr_w(depth) returning log2(depth)+1.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH): push/pop/full/empty/head. The FSM, decode and watchdog stay in mmio_console_monitor.

Test Plan:
- Stores of 'H' then 'i' to 65532 with char_ready=1 -> char_valid=1 with 0x48 on the cycle after the first store, then 0x69; no overflow.
- char_ready=0, 17 console stores with FIFO_DEPTH=16 -> fifo_overflow=1; releasing char_ready yields exactly 16 characters in order.
- Push and pop in the same cycle while full -> no overflow; occupancy stays 16; order preserved.
- 3 characters queued, char_ready=0, tohost store of 1 -> done stays 0; after char_ready=1 pops all 3 -> done=1, pass=1, fail_code=0.
- tohost store of 7 -> done=1, pass=0, fail_code=3; a later store of 1 is ignored.
- No tohost store, TIMEOUT_CYCLES=50 -> timeout=1 at cycle 50; done follows once the FIFO is empty; assert reset -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/console_pkg.sv
// Shared types and defaults for the MMIO console/test-status monitor.
// The test-status FSM states and the FIFO pointer sizing helper live here.
package console_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } console_state_t;

    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'd65532;
    localparam logic [31:0] DEF_TOHOST_ADDR  = 32'd65528;

    // Index bits plus one wrap bit so full and empty can be told apart.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mmio_console_monitor_sync_fifo.sv
// sync_fifo: generic power-of-two character buffer with wrap-bit full/empty decode.
// Latency: a push is visible at head after one clk edge; the caller gates push/pop against full/empty.
module sync_fifo
    import console_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mmio_console_monitor.sv
// mmio_console_monitor: snoops core stores; console chars stream out, tohost/watchdog end the test.
// Latency: char_valid one edge after a console store. Backpressure: char_ready stalls the stream;
// a store into a full FIFO without a same-cycle pop is dropped (sticky fifo_overflow). Option macro: CONSOLE_SIM_PRINT_EN.
module mmio_console_monitor
    import console_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDR   = DEF_CONSOLE_ADDR,
    parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          CHAR_W         = 8,
    parameter int          TIMEOUT_CYCLES = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       dataadr,
    input  logic [31:0]       writedata,
    input  logic              char_ready,
    output logic              char_valid,
    output logic [CHAR_W-1:0] char_data,
    output logic              fifo_overflow,
    output logic              done,
    output logic              pass,
    output logic [30:0]       fail_code,
    output logic              timeout
);

    console_state_t state_q, state_d;
    logic [31:0]    cycle_q, cycle_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic [30:0]    fail_code_q, fail_code_d;
    logic           timeout_q, timeout_d;

    logic              fifo_full, fifo_empty;
    logic [CHAR_W-1:0] fifo_head;
    logic              console_hit, tohost_hit, wd_expire;
    logic              fifo_push, fifo_pop;

    assign console_hit = memwrite && (dataadr == CONSOLE_ADDR) && (state_q == RUN);
    assign tohost_hit  = memwrite && (dataadr == TOHOST_ADDR) && writedata[0] && (state_q == RUN);
    assign wd_expire   = (TIMEOUT_CYCLES != 0) && (state_q == RUN) &&
                         (cycle_q == 32'(TIMEOUT_CYCLES - 1));

    // A full FIFO still takes a store when the sink frees a slot on the same edge.
    assign fifo_pop  = !fifo_empty && char_ready;
    assign fifo_push = console_hit && (!fifo_full || fifo_pop);

    sync_fifo #(
        .WIDTH (CHAR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (writedata[CHAR_W-1:0]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        ovf_d       = ovf_q || (console_hit && fifo_full && !fifo_pop);
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        timeout_d   = timeout_q;
        case (state_q)
            RUN: begin
                cycle_d = cycle_q + 32'd1;
                if (tohost_hit) begin
                    pass_d      = (writedata == 32'd1);
                    fail_code_d = (writedata == 32'd1) ? 31'd0 : writedata[31:1];
                    state_d     = DRAIN;
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            cycle_q     <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            timeout_q   <= timeout_d;
        end
    end

    assign char_valid    = !fifo_empty;
    assign char_data     = fifo_empty ? '0 : fifo_head;
    assign fifo_overflow = ovf_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_code     = fail_code_q;
    assign timeout       = timeout_q;

`ifdef CONSOLE_SIM_PRINT_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (fifo_pop) $write("%c", char_data);
            if ((state_q != DONE) && (state_d == DONE)) begin
                if (timeout_q)   $display("TIMEOUT");
                else if (pass_q) $display("PASS");
                else             $display("FAIL %0d", fail_code_q);
                $finish;
            end
        end
    end
`else
    // Synthesizable build: console traffic is visible only on the char stream ports.
`endif

endmodule

// File: tb/tb_mmio_console_monitor.sv
// Self-checking bench for mmio_console_monitor: directed test-plan scenarios plus randomized
// store/backpressure traffic compared against a queue-based reference model.
module tb_mmio_console_monitor;

    localparam logic [31:0] CON   = 32'd65532;
    localparam logic [31:0] TH    = 32'd65528;
    localparam int          DEPTH = 16;
    localparam int          TO    = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        char_ready = 1'b0;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        fifo_overflow;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;
    logic        timeout;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    bit          m_ovf, m_over, m_pass, m_to;
    logic [30:0] m_code;
    int          m_cyc;

    mmio_console_monitor #(
        .CONSOLE_ADDR   (CON),
        .TOHOST_ADDR    (TH),
        .FIFO_DEPTH     (DEPTH),
        .CHAR_W         (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .memwrite      (memwrite),
        .dataadr       (dataadr),
        .writedata     (writedata),
        .char_ready    (char_ready),
        .char_valid    (char_valid),
        .char_data     (char_data),
        .fifo_overflow (fifo_overflow),
        .done          (done),
        .pass          (pass),
        .fail_code     (fail_code),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs (called at a negedge), advance the model, return at the next negedge.
    task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
        bit popd, run;
        int pre;
        memwrite = mw; dataadr = adr; writedata = wd; char_ready = rdy;
        pre  = m_q.size();
        run  = !m_over;
        popd = (pre > 0) && rdy;
        if (popd) void'(m_q.pop_front());
        if (run && mw && adr == CON) begin
            if (pre < DEPTH || popd) m_q.push_back(wd[7:0]);
            else m_ovf = 1'b1;
        end
        if (run && mw && adr == TH && wd[0]) begin
            m_over = 1'b1;
            m_pass = (wd == 32'd1);
            m_code = m_pass ? 31'd0 : wd[31:1];
        end else if (run && m_cyc == TO - 1) begin
            m_over = 1'b1;
            m_to   = 1'b1;
            m_pass = 1'b0;
        end
        if (run) m_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; char_ready = 1'b0;
        repeat (2) @(negedge clk);
        m_q.delete();
        m_ovf = 0; m_over = 0; m_pass = 0; m_to = 0; m_code = '0; m_cyc = 0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({char_valid, char_data, fifo_overflow, done, pass, fail_code, timeout} !== '0) begin
            bad++;
            $display("FAIL reset_state: v=%b d=%h ovf=%b done=%b pass=%b code=%0d to=%b want all 0",
                     char_valid, char_data, fifo_overflow, done, pass, fail_code, timeout);
        end
    endtask

    task automatic test_hi();
        do_reset();
        step(1'b1, CON, 32'h48, 1'b1);
        total++;
        if (char_valid !== 1'b1 || char_data !== 8'h48) begin
            bad++; $display("FAIL hi_first: v=%b d=%h want 1 48", char_valid, char_data);
        end
        step(1'b1, CON, 32'h69, 1'b1);
        total++;
        if (char_valid !== 1'b1 || char_data !== 8'h69) begin
            bad++; $display("FAIL hi_second: v=%b d=%h want 1 69", char_valid, char_data);
        end
        step(1'b0, 32'd0, 32'd0, 1'b1);
        total++;
        if (char_valid !== 1'b0 || fifo_overflow !== 1'b0) begin
            bad++; $display("FAIL hi_idle: v=%b ovf=%b want 0 0", char_valid, fifo_overflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, CON, 32'h41 + i, 1'b0);
        total++;
        if (fifo_overflow !== 1'b1 || char_valid !== 1'b1 || char_data !== 8'h41) begin
            bad++; $display("FAIL ovf_set: ovf=%b v=%b d=%h want 1 1 41", fifo_overflow, char_valid, char_data);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (char_valid !== 1'b1 || char_data !== 8'(8'h41 + i)) begin
                bad++; $display("FAIL ovf_drain[%0d]: v=%b d=%h want 1 %h", i, char_valid, char_data, 8'(8'h41 + i));
            end
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        total++;
        if (char_valid !== 1'b0 || fifo_overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_empty: v=%b ovf=%b want 0 1", char_valid, fifo_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, CON, 32'h30 + i, 1'b0);
        step(1'b1, CON, 32'h40, 1'b1);
        total++;
        if (fifo_overflow !== 1'b0 || char_data !== 8'h31) begin
            bad++; $display("FAIL full_pushpop: ovf=%b d=%h want 0 31", fifo_overflow, char_data);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'(8'h31 + i) : 8'h40;
            total++;
            if (char_valid !== 1'b1 || char_data !== exp) begin
                bad++; $display("FAIL full_order[%0d]: v=%b d=%h want 1 %h", i, char_valid, char_data, exp);
            end
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        total++;
        if (char_valid !== 1'b0) begin
            bad++; $display("FAIL full_count: v=%b want 0 after 16 pops", char_valid);
        end
    endtask

    task automatic test_drain_pass();
        int popped;
        popped = 0;
        do_reset();
        step(1'b1, CON, 32'h61, 1'b0);
        step(1'b1, CON, 32'h62, 1'b0);
        step(1'b1, CON, 32'h63, 1'b0);
        step(1'b1, TH, 32'd1, 1'b0);
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b0);
        total++;
        if (done !== 1'b0 || char_valid !== 1'b1) begin
            bad++; $display("FAIL drain_hold: done=%b v=%b want 0 1", done, char_valid);
        end
        for (int k = 0; k < 10 && done !== 1'b1; k++) begin
            if (char_valid === 1'b1) popped++;
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        total++;
        if (done !== 1'b1 || pass !== 1'b1 || fail_code !== 31'd0 || popped != 3) begin
            bad++; $display("FAIL drain_pass: done=%b pass=%b code=%0d pops=%0d want 1 1 0 3",
                            done, pass, fail_code, popped);
        end
    endtask

    task automatic test_fail_code();
        do_reset();
        step(1'b1, TH, 32'd2, 1'b1);
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL tohost_even: done=%b want 0", done);
        end
        step(1'b1, TH, 32'd7, 1'b1);
        for (int k = 0; k < 5 && done !== 1'b1; k++) step(1'b0, 32'd0, 32'd0, 1'b1);
        total++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 31'd3 || timeout !== 1'b0) begin
            bad++; $display("FAIL fail7: done=%b pass=%b code=%0d to=%b want 1 0 3 0", done, pass, fail_code, timeout);
        end
        step(1'b1, TH, 32'd1, 1'b1);
        repeat (2) step(1'b0, 32'd0, 32'd0, 1'b1);
        total++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 31'd3) begin
            bad++; $display("FAIL late_store: done=%b pass=%b code=%0d want 1 0 3", done, pass, fail_code);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, CON, 32'h70 + i, 1'b0);
        for (int i = 17; i < TO - 1; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
        total++;
        if (timeout !== 1'b0) begin
            bad++; $display("FAIL to_early: timeout=%b want 0 at cycle %0d", timeout, TO - 1);
        end
        step(1'b0, 32'd0, 32'd0, 1'b0);
        total++;
        if (timeout !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL to_fire: timeout=%b done=%b want 1 0", timeout, done);
        end
        for (int k = 0; k < 25 && done !== 1'b1; k++) step(1'b0, 32'd0, 32'd0, 1'b1);
        total++;
        if (done !== 1'b1 || pass !== 1'b0 || char_valid !== 1'b0 || fifo_overflow !== 1'b1) begin
            bad++; $display("FAIL to_done: done=%b pass=%b v=%b ovf=%b want 1 0 0 1", done, pass, char_valid, fifo_overflow);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({char_valid, char_data, fifo_overflow, done, pass, fail_code, timeout} !== '0) begin
            bad++; $display("FAIL async_reset: done=%b ovf=%b to=%b pass=%b want all 0", done, fifo_overflow, timeout, pass);
        end
    endtask

    task automatic test_random();
        logic        mw, rdy;
        logic [31:0] adr, wd;
        int          a, n;
        for (int it = 0; it < 15; it++) begin
            do_reset();
            n = $urandom_range(30, 70);
            for (int c = 0; c < n; c++) begin
                total++;
                if (char_valid !== (m_q.size() > 0) || fifo_overflow !== m_ovf || timeout !== m_to ||
                    (m_q.size() > 0 && char_data !== m_q[0])) begin
                    bad++; $display("FAIL rand[%0d.%0d]: v=%b d=%h ovf=%b to=%b want %b %h %b %b", it, c,
                                    char_valid, char_data, fifo_overflow, timeout,
                                    m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : 8'h00, m_ovf, m_to);
                end
                total++;
                if (done === 1'b1 && !(m_over && m_q.size() == 0)) begin
                    bad++; $display("FAIL rand_done[%0d.%0d]: done=1 want 0 (queued=%0d)", it, c, m_q.size());
                end
                mw  = ($urandom_range(0, 99) < 60);
                a   = $urandom_range(0, 19);
                adr = (a < 14) ? CON : (a == 14) ? TH : 32'h1000 + 32'(a);
                case ($urandom_range(0, 2))
                    0:       wd = 32'd1;
                    1:       wd = $urandom | 32'd1;
                    default: wd = $urandom;
                endcase
                rdy = ($urandom_range(0, 1) == 1);
                step(mw, adr, wd, rdy);
            end
            for (int k = 0; k < 80 && done !== 1'b1; k++) step(1'b0, 32'd0, 32'd0, 1'b1);
            total++;
            if (done !== 1'b1 || pass !== m_pass || timeout !== m_to || fail_code !== m_code) begin
                bad++; $display("FAIL rand_end[%0d]: done=%b pass=%b to=%b code=%0d want 1 %b %b %0d",
                                it, done, pass, timeout, fail_code, m_pass, m_to, m_code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hi();
        test_overflow();
        test_full_push_pop();
        test_drain_pass();
        test_fail_code();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
